feynman_fanout_pipe: RTL

- Parametrised, pipelined multi-target Feynman (CNOT fan-out) gate; successor to the 3-line double Feynman gate.
- One control word drives NTARGET target words: P = A, Ti' = Ti XOR (A AND en_i).
- Two-stage valid/ready pipeline, one transfer per cycle, with a transfer counter.
- Sits between reversible-logic stimulus sources and downstream reversible cascades. The gate is self-inverse, so cascades can chain it without extra handling.

---
 rtl/reversible_pkg.sv | 42 ++++
 rtl/feynman_fanout_pipe_stage.sv | 30 +++
 rtl/feynman_fanout_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/reversible_pkg.sv
// Shared types and the XOR fan-out helper for reversible-logic pipelines.
// Default line widths and upper bounds for the fan-out helper live here.
package reversible_pkg;

  localparam int DEF_WIDTH   = 1;
  localparam int DEF_NTARGET = 2;

  localparam int MAX_W = 64;
  localparam int MAX_T = 16;
  localparam int MAX_B = MAX_W * MAX_T;

  localparam int WI_W = $clog2(MAX_W);
  localparam int TI_W = $clog2(MAX_T);
  localparam int BI_W = $clog2(MAX_B);

  typedef struct packed {
    logic [DEF_NTARGET-1:0]           en;
    logic [DEF_NTARGET*DEF_WIDTH-1:0] tgt;
    logic [DEF_WIDTH-1:0]             ctrl;
  } feynman_word_t;

  // Lane i of tgt is XORed with ctrl when en[i] is set; w and n are the
  // real lane width and lane count, anything above them passes through.
  function automatic logic [MAX_B-1:0] feynman_apply(
    input logic [MAX_W-1:0] ctrl,
    input logic [MAX_B-1:0] tgt,
    input logic [MAX_T-1:0] en,
    input int               w,
    input int               n
  );
    logic [MAX_B-1:0] r;
    r = tgt;
    for (int k = 0; k < MAX_B; k++) begin
      if (k < w * n) begin
        r[BI_W'(k)] = tgt[BI_W'(k)]
                    ^ (ctrl[WI_W'(k % w)] & en[TI_W'(k / w)]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/feynman_fanout_pipe_stage.sv
// Generic valid/ready register slice; accept and drain may share a cycle.
// Ready is purely combinational from the local valid and downstream ready.
module rev_pipe_stage
  import reversible_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/feynman_fanout_pipe.sv
// Two-stage multi-target Feynman (CNOT fan-out) gate with transfer counter.
// FEYNMAN_SELFCHECK_EN adds a sticky re-apply self-check on check_err.
module feynman_fanout_pipe
  import reversible_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NTARGET = DEF_NTARGET,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_ctrl,
  input  logic [NTARGET*WIDTH-1:0] in_tgt,
  input  logic [NTARGET-1:0]       in_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_ctrl,
  output logic [NTARGET*WIDTH-1:0] out_tgt,
  output logic                     busy,
  output logic [CNT_W-1:0]         xfer_count,
  output logic                     check_err
);

  localparam int TW = NTARGET * WIDTH;
  localparam int DW = NTARGET + TW + WIDTH;
`ifdef FEYNMAN_SELFCHECK_EN
  localparam int SW = TW + WIDTH + DW;
`else
  localparam int SW = TW + WIDTH;
`endif

  if (WIDTH < 1 || NTARGET < 1 || WIDTH > MAX_W || NTARGET > MAX_T)
  begin : g_bad_params
    $error("feynman_fanout_pipe: unsupported WIDTH/NTARGET");
  end

  logic          s1_valid;
  logic          s2_valid;
  logic          s2_ready;
  logic [DW-1:0] s1_data;
  logic [SW-1:0] s2_in;
  logic [SW-1:0] s2_data;
  logic [TW-1:0] s1_res;

  rev_pipe_stage #(.DW(DW)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_en, in_tgt, in_ctrl}),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_data)
  );

  assign s1_res = TW'(feynman_apply(
    MAX_W'(s1_data[WIDTH-1:0]),
    MAX_B'(s1_data[WIDTH +: TW]),
    MAX_T'(s1_data[DW-1 -: NTARGET]),
    WIDTH, NTARGET));

`ifdef FEYNMAN_SELFCHECK_EN
  assign s2_in = {s1_data, s1_res, s1_data[WIDTH-1:0]};
`else
  assign s2_in = {s1_res, s1_data[WIDTH-1:0]};
`endif

  rev_pipe_stage #(.DW(SW)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (s2_in),
    .out_valid(s2_valid),
    .out_ready(out_ready),
    .out_data (s2_data)
  );

  assign out_valid = s2_valid;
  assign out_ctrl  = s2_data[WIDTH-1:0];
  assign out_tgt   = s2_data[WIDTH +: TW];
  assign busy      = s1_valid | s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (s2_valid && out_ready) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

`ifdef FEYNMAN_SELFCHECK_EN
  // The gate is self-inverse: re-applying it must reproduce the source.
  logic [DW-1:0] src;
  logic [TW-1:0] redo;

  assign src  = s2_data[SW-1 -: DW];
  assign redo = TW'(feynman_apply(
    MAX_W'(out_ctrl),
    MAX_B'(out_tgt),
    MAX_T'(src[DW-1 -: NTARGET]),
    WIDTH, NTARGET));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_err <= 1'b0;
    end else if (s2_valid &&
                 (redo != src[WIDTH +: TW] ||
                  out_ctrl != src[WIDTH-1:0])) begin
      check_err <= 1'b1;
    end
  end
`else
  assign check_err = 1'b0;
`endif

endmodule
